bsg_mem_1rw_sync_mask_write_bit_init_ctrl: RTL and testbench

//  Front-end placed directly upstream of a 1RW sync bit-masked-write memory (hard macro or synth).

---
 rtl/bsg_mem_init_ctrl_pkg.sv | 15 +
 rtl/bsg_mem_1rw_sync_mask_write_bit_synth.sv | 36 +++
 rtl/bsg_mem_init_ctrl_sweep.sv | 33 +++
 rtl/bsg_mem_1rw_sync_mask_write_bit_init_ctrl.sv | 131 +++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_init_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_mem_init_ctrl_pkg.sv
// Shared types and helpers for the 1RW mask-write memory init controller.
// The sweep writes a fixed value to every word before client traffic is admitted.
package bsg_mem_init_ctrl_pkg;

    typedef enum logic [0:0] {
        eInit  = 1'b0,
        eReady = 1'b1
    } state_e;

    // Address width that never collapses to zero bits for tiny memories.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_synth.sv
// Behavioural 1RW synchronous memory with per-bit write mask; read data registered.
// Latency: read data valid the cycle after v_i & ~w_i; no backpressure.
module bsg_mem_1rw_sync_mask_write_bit_synth
    import bsg_mem_init_ctrl_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 2,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            mem[addr_i] <= (mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= '0;
        end else if (v_i & ~w_i) begin
            data_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/bsg_mem_init_ctrl_sweep.sv
// Sweep address counter: clear has priority over enable, last_o flags word els_p-1.
// Latency: count updates on the clock edge after en_i; no backpressure (driven by FSM).
module bsg_mem_init_ctrl_sweep
    import bsg_mem_init_ctrl_pkg::*;
#(
    parameter int els_p = 2,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     en_i,
    output logic [addr_width_lp-1:0] cnt_o,
    output logic                     last_o
);

    logic [addr_width_lp-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Explicit compare rather than wrap so non-power-of-2 depths stop at the right word.
    assign last_o = (cnt_q == addr_width_lp'(els_p - 1));
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_init_ctrl.sv
// Init/clear front-end for a 1RW sync bit-masked memory: sweeps init_val_p, then forwards client requests.
// Read data returns one cycle after acceptance; ready_o is low while sweeping or when init_i is raised.
// Optional BSG_MEM_INIT_CTRL_LATCH_READ_EN holds data_o at the last read value between reads.
module bsg_mem_1rw_sync_mask_write_bit_init_ctrl
    import bsg_mem_init_ctrl_pkg::*;
#(
    parameter int                 width_p    = 1,
    parameter int                 els_p      = 2,
    parameter logic [width_p-1:0] init_val_p = '0,
    localparam int                addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     init_i,
    output logic                     init_done_o,

    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,

    output logic [width_p-1:0]       data_o,
    output logic                     data_v_o,

    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_lp-1:0] mem_addr_o,
    output logic [width_p-1:0]       mem_data_o,
    output logic [width_p-1:0]       mem_w_mask_o,
    input  logic [width_p-1:0]       mem_data_i
);

    state_e                   state_q, state_n;
    logic                     cnt_clear, cnt_en, cnt_last;
    logic [addr_width_lp-1:0] cnt;
    logic                     rd_accept;
    logic                     rd_v_q;

    bsg_mem_init_ctrl_sweep #(
        .els_p (els_p)
    ) sweep (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eInit;
        end else begin
            state_q <= state_n;
        end
    end

    // Client fields pass through whenever not sweeping, so idle mem_* never go X.
    always_comb begin
        state_n      = state_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        ready_o      = 1'b0;
        mem_v_o      = 1'b0;
        mem_w_o      = w_i;
        mem_addr_o   = addr_i;
        mem_data_o   = data_i;
        mem_w_mask_o = w_mask_i;
        case (state_q)
            eInit: begin
                mem_v_o      = 1'b1;
                mem_w_o      = 1'b1;
                mem_addr_o   = cnt;
                mem_data_o   = init_val_p;
                mem_w_mask_o = '1;
                if (cnt_last) begin
                    cnt_clear = 1'b1;
                    state_n   = eReady;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            eReady: begin
                // A new sweep request takes priority over a same-cycle client request.
                ready_o = ~init_i;
                mem_v_o = v_i & ~init_i;
                if (init_i) begin
                    cnt_clear = 1'b1;
                    state_n   = eInit;
                end
            end
            default: begin
                state_n = eInit;
            end
        endcase
    end

    assign init_done_o = (state_q == eReady);
    assign rd_accept   = v_i & ready_o & ~w_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_v_q <= 1'b0;
        end else begin
            rd_v_q <= rd_accept;
        end
    end

    assign data_v_o = rd_v_q;

`ifdef BSG_MEM_INIT_CTRL_LATCH_READ_EN
    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (rd_v_q) begin
            data_q <= mem_data_i;
        end
    end

    // Fresh data bypasses the holding register so the return cycle matches the unlatched build.
    assign data_o = rd_v_q ? mem_data_i : data_q;
`else
    assign data_o = rd_v_q ? mem_data_i : '0;
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_init_ctrl.sv
// Directed bench: init controller in front of the synth mask-write memory, 64 x 15 bits.
module tb_bsg_mem_1rw_sync_mask_write_bit_init_ctrl;

    localparam int W  = 15;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam logic [W-1:0] INIT = 15'h5A5A;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          init_i;
    logic          init_done_o;
    logic          v_i;
    logic          ready_o;
    logic          w_i;
    logic [AW-1:0] addr_i;
    logic [W-1:0]  data_i;
    logic [W-1:0]  w_mask_i;
    logic [W-1:0]  data_o;
    logic          data_v_o;
    logic          mem_v_o;
    logic          mem_w_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_data_o;
    logic [W-1:0]  mem_w_mask_o;
    logic [W-1:0]  mem_data_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bsg_mem_1rw_sync_mask_write_bit_init_ctrl #(
        .width_p    (W),
        .els_p      (N),
        .init_val_p (INIT)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .init_i       (init_i),
        .init_done_o  (init_done_o),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .w_mask_i     (w_mask_i),
        .data_o       (data_o),
        .data_v_o     (data_v_o),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_w_mask_o (mem_w_mask_o),
        .mem_data_i   (mem_data_i)
    );

    bsg_mem_1rw_sync_mask_write_bit_synth #(
        .width_p (W),
        .els_p   (N)
    ) mem (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (mem_v_o),
        .w_i      (mem_w_o),
        .addr_i   (mem_addr_o),
        .data_i   (mem_data_o),
        .w_mask_i (mem_w_mask_o),
        .data_o   (mem_data_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        v_i = 1'b0; w_i = 1'b0; init_i = 1'b0;
    endtask

    // Single read: accept, then check the return on the following cycle.
    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        v_i = 1'b1; w_i = 1'b0; addr_i = a;
        tick();
        idle();
        #1;
        check({tag, "_dv"}, 32'(data_v_o), 32'd1);
        check({tag, "_dat"}, 32'(data_o), 32'(exp));
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
        tick();
        idle();
    endtask

    // Walk a whole sweep, checking every issued write; init pulse at cycle pulse_at if >= 0.
    task automatic sweep_check(input string tag, input int pulse_at);
        int bad = 0;
        for (int c = 0; c < N; c++) begin
            init_i = (c == pulse_at);
            #1;
            if (!(mem_v_o === 1'b1 && mem_w_o === 1'b1 && mem_addr_o === AW'(c) &&
                  mem_data_o === INIT && mem_w_mask_o === '1 &&
                  ready_o === 1'b0 && init_done_o === 1'b0)) bad++;
            tick();
        end
        init_i = 1'b0;
        check({tag, "_sweep_bad_cycles"}, 32'(bad), 32'd0);
        check({tag, "_done"}, 32'(init_done_o), 32'd1);
    endtask

    initial begin
        reset_i = 1'b1; init_i = 1'b0; v_i = 1'b0; w_i = 1'b0;
        addr_i = '0; data_i = '0; w_mask_i = '0;
        #2;
        check("rst_done", 32'(init_done_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_dv", 32'(data_v_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);

        // Pending read held from reset: must wait out the sweep and be served once.
        v_i = 1'b1; w_i = 1'b0; addr_i = AW'(7);
        tick(); tick();
        reset_i = 1'b0;
        sweep_check("t1", -1);
        check("t4_ready", 32'(ready_o), 32'd1);
        check("t4_mem_v", 32'(mem_v_o), 32'd1);
        check("t4_mem_w", 32'(mem_w_o), 32'd0);
        check("t4_mem_addr", 32'(mem_addr_o), 32'd7);
        tick();
        idle();
        #1;
        check("t4_dv", 32'(data_v_o), 32'd1);
        check("t4_data", 32'(data_o), 32'h5A5A);
        tick();
        check("t4_single_dv", 32'(data_v_o), 32'd0);
        check("idle_mem_v", 32'(mem_v_o), 32'd0);

        // Back-to-back reads of every word return the init value.
        begin
            int bad = 0;
            v_i = 1'b1; w_i = 1'b0; addr_i = '0;
            for (int a = 1; a <= N; a++) begin
                tick();
                if (!(data_v_o === 1'b1 && data_o === INIT)) bad++;
                addr_i = AW'(a);
                if (a == N) idle();
            end
            check("t1_all_reads_bad", 32'(bad), 32'd0);
        end
        tick();
        check("t1_idle_dv", 32'(data_v_o), 32'd0);
`ifdef BSG_MEM_INIT_CTRL_LATCH_READ_EN
        check("t1_idle_data", 32'(data_o), 32'h5A5A);
`else
        check("t1_idle_data", 32'(data_o), 32'd0);
`endif

        // Masked write: only bits 7:4 take the new data.
        write(AW'(3), 15'h7FFF, 15'h00F0);
        #1;
        check("t2_write_no_dv", 32'(data_v_o), 32'd0);
        read_check("t2_masked", AW'(3), 15'h5AFA);

        // Three consecutive reads give three in-order returns.
        write(AW'(0), 15'h0111, '1);
        write(AW'(1), 15'h0222, '1);
        write(AW'(2), 15'h0333, '1);
        v_i = 1'b1; w_i = 1'b0; addr_i = AW'(0);
        tick();
        check("t3_r0_dv", 32'(data_v_o), 32'd1);
        check("t3_r0", 32'(data_o), 32'h0111);
        addr_i = AW'(1);
        tick();
        check("t3_r1_dv", 32'(data_v_o), 32'd1);
        check("t3_r1", 32'(data_o), 32'h0222);
        addr_i = AW'(2);
        tick();
        idle();
        #1;
        check("t3_r2_dv", 32'(data_v_o), 32'd1);
        check("t3_r2", 32'(data_o), 32'h0333);
        tick();
        check("t3_end_dv", 32'(data_v_o), 32'd0);

        // Re-init after a read: the read still returns, the init cycle blocks new requests.
        write(AW'(10), 15'h1234, '1);
        read_check("t5_pre", AW'(10), 15'h1234);
        v_i = 1'b1; w_i = 1'b0; addr_i = AW'(10);
        tick();
        init_i = 1'b1;
        #1;
        check("t5_init_ready", 32'(ready_o), 32'd0);
        check("t5_init_mem_v", 32'(mem_v_o), 32'd0);
        check("t5_inflight_dv", 32'(data_v_o), 32'd1);
        check("t5_inflight_data", 32'(data_o), 32'h1234);
        tick();
        idle();
        #1;
        check("t5_done_fell", 32'(init_done_o), 32'd0);
        check("t5_no_extra_dv", 32'(data_v_o), 32'd0);
        sweep_check("t5", 20);
        read_check("t5_cleared", AW'(10), INIT);
        read_check("t5_cleared3", AW'(3), INIT);

        // Async reset while a read is returning.
        v_i = 1'b1; w_i = 1'b0; addr_i = AW'(5);
        tick();
        idle();
        #1;
        check("t6_pre_dv", 32'(data_v_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check("t6_rst_dv", 32'(data_v_o), 32'd0);
        check("t6_rst_data", 32'(data_o), 32'd0);
        check("t6_rst_done", 32'(init_done_o), 32'd0);
        check("t6_rst_ready", 32'(ready_o), 32'd0);
        tick();
        reset_i = 1'b0;

        // Async reset at sweep cycle 30, then a full restart from address 0.
        for (int c = 0; c < 30; c++) tick();
        check("t6_mid_addr", 32'(mem_addr_o), 32'd30);
        #2;
        reset_i = 1'b1;
        #1;
        check("t6_mid_rst_addr", 32'(mem_addr_o), 32'd0);
        check("t6_mid_rst_done", 32'(init_done_o), 32'd0);
        tick();
        reset_i = 1'b0;
        sweep_check("t6", -1);
        read_check("t6_final", AW'(10), INIT);
        tick();
        check("t6_idle_dv", 32'(data_v_o), 32'd0);
`ifdef BSG_MEM_INIT_CTRL_LATCH_READ_EN
        check("t6_idle_data", 32'(data_o), 32'(INIT));
`else
        check("t6_idle_data", 32'(data_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
